// File: rtl/regfile_loader_pkg.sv
// Shared definitions for the regfile loader: FSM state encoding and host command layout.
package regfile_loader_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_ADDR_H,
    S_ADDR_L,
    S_CNT_H,
    S_CNT_L,
    S_DATA,
    S_WRITE,
    S_FINISH,
    S_ERR
  } loader_state_t;

  localparam int CMD_TGT   = 0;
  localparam int CMD_START = 1;
  localparam int HDR_LEN   = 5;

  // A command byte is only legal when its reserved upper six bits are clear.
  function automatic logic cmd_reserved_ok(input logic [5:0] reserved);
    return reserved == 6'd0;
  endfunction

endpackage

// File: rtl/regfile_loader_if.sv
// Host byte stream plus accelerator random-write ports for the regfile loader.
interface regfile_loader_if #(
  parameter int ADDR_W  = 12,
  parameter int DATA_W  = 32,
  parameter int STATE_W = 18
);

  logic               in_valid;
  logic [7:0]         in_data;
  logic               in_ready;
  logic               clear_err;

  logic               ran_we_InexRecur;
  logic [ADDR_W-1:0]  ran_w_addr_InexRecur;
  logic [DATA_W-1:0]  ran_w_data_InexRecur;
  logic               ran_we_state_external;
  logic [ADDR_W-1:0]  ran_w_addr_state_external;
  logic [STATE_W-1:0] ran_w_data_state_external;

  logic               is_start;
  logic               busy;
  logic               done;
  logic               err;

  modport slave (
    input  in_valid, in_data, clear_err,
    output in_ready,
    output ran_we_InexRecur, ran_w_addr_InexRecur, ran_w_data_InexRecur,
    output ran_we_state_external, ran_w_addr_state_external, ran_w_data_state_external,
    output is_start, busy, done, err
  );

  modport master (
    output in_valid, in_data, clear_err,
    input  in_ready,
    input  ran_we_InexRecur, ran_w_addr_InexRecur, ran_w_data_InexRecur,
    input  ran_we_state_external, ran_w_addr_state_external, ran_w_data_state_external,
    input  is_start, busy, done, err
  );

endinterface

// File: rtl/regfile_loader_byte_packer.sv
// Collects four stream bytes MSB-first into one word; word_full flags the byte that completes it.
module byte_packer #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear,
  input  logic              shift_en,
  input  logic [7:0]        byte_in,
  output logic [WORD_W-1:0] word_next,
  output logic              word_full
);

  logic [WORD_W-9:0] partial;
  logic [1:0]        byte_idx;

  // Only the first three bytes need storage; the fourth is merged on the fly.
  assign word_next = {partial, byte_in};
  assign word_full = shift_en && (byte_idx == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      partial  <= '0;
      byte_idx <= 2'd0;
    end else if (clear) begin
      partial  <= '0;
      byte_idx <= 2'd0;
    end else if (shift_en) begin
      partial  <= word_next[WORD_W-9:0];
      byte_idx <= byte_idx + 2'd1;
    end
  end

endmodule

// File: rtl/regfile_loader.sv
// Parses framed host commands and issues one registered write pulse per packed word
// into the InexRecur or state regfile, optionally followed by an accelerator start pulse.
module regfile_loader
  import regfile_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 32,
  parameter int STATE_W   = 18,
  parameter int MAX_WORDS = 4096
) (
  input logic              clk,
  input logic              rst_n,
  regfile_loader_if.slave  bus
);

  localparam logic [15:0] MAX_CNT = 16'(MAX_WORDS);

  loader_state_t     state;
  logic              tgt_state;
  logic              start_after;
  logic [7:0]        addr_hi;
  logic [7:0]        cnt_hi;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       cnt_q;
  logic [15:0]       cnt_full;
  logic              accept;
  logic [DATA_W-1:0] word_next;
  logic              word_full;

  assign accept      = bus.in_valid && bus.in_ready;
  assign cnt_full    = {cnt_hi, bus.in_data};
  assign bus.in_ready = !(state inside {S_WRITE, S_FINISH, S_ERR});
  assign bus.busy     = !(state inside {S_IDLE, S_ERR});
  assign bus.err      = (state == S_ERR);

  byte_packer #(.WORD_W(DATA_W)) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (state == S_IDLE),
    .shift_en  (accept && (state == S_DATA)),
    .byte_in   (bus.in_data),
    .word_next (word_next),
    .word_full (word_full)
  );

  // Strobes, done and is_start default low so each fires for exactly one cycle;
  // the address/data registers of the unselected port keep their last values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                         <= S_IDLE;
      tgt_state                     <= 1'b0;
      start_after                   <= 1'b0;
      addr_hi                       <= 8'd0;
      cnt_hi                        <= 8'd0;
      addr_q                        <= '0;
      cnt_q                         <= 16'd0;
      bus.ran_we_InexRecur          <= 1'b0;
      bus.ran_w_addr_InexRecur      <= '0;
      bus.ran_w_data_InexRecur      <= '0;
      bus.ran_we_state_external     <= 1'b0;
      bus.ran_w_addr_state_external <= '0;
      bus.ran_w_data_state_external <= '0;
      bus.done                      <= 1'b0;
      bus.is_start                  <= 1'b0;
    end else begin
      bus.ran_we_InexRecur      <= 1'b0;
      bus.ran_we_state_external <= 1'b0;
      bus.done                  <= 1'b0;
      bus.is_start              <= 1'b0;
      unique case (state)
        S_IDLE: if (accept) begin
          if (cmd_reserved_ok(bus.in_data[7:2])) begin
            tgt_state   <= bus.in_data[CMD_TGT];
            start_after <= bus.in_data[CMD_START];
            state       <= S_ADDR_H;
          end else begin
            state <= S_ERR;
          end
        end
        S_ADDR_H: if (accept) begin
          addr_hi <= bus.in_data;
          state   <= S_ADDR_L;
        end
        S_ADDR_L: if (accept) begin
          addr_q <= ADDR_W'({addr_hi, bus.in_data});
          state  <= S_CNT_H;
        end
        S_CNT_H: if (accept) begin
          cnt_hi <= bus.in_data;
          state  <= S_CNT_L;
        end
        S_CNT_L: if (accept) begin
          cnt_q <= cnt_full;
          if (cnt_full == 16'd0) begin
            state        <= S_FINISH;
            bus.done     <= 1'b1;
            bus.is_start <= start_after;
          end else if (cnt_full > MAX_CNT) begin
            state <= S_ERR;
          end else begin
            state <= S_DATA;
          end
        end
        S_DATA: if (word_full) begin
          state <= S_WRITE;
          if (tgt_state) begin
            bus.ran_we_state_external     <= 1'b1;
            bus.ran_w_addr_state_external <= addr_q;
            bus.ran_w_data_state_external <= word_next[STATE_W-1:0];
          end else begin
            bus.ran_we_InexRecur     <= 1'b1;
            bus.ran_w_addr_InexRecur <= addr_q;
            bus.ran_w_data_InexRecur <= word_next;
          end
        end
        S_WRITE: begin
          addr_q <= addr_q + ADDR_W'(1);
          cnt_q  <= cnt_q - 16'd1;
          if (cnt_q == 16'd1) begin
            state        <= S_FINISH;
            bus.done     <= 1'b1;
            bus.is_start <= start_after;
          end else begin
            state <= S_DATA;
          end
        end
        S_FINISH: state <= S_IDLE;
        S_ERR:    if (bus.clear_err) state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_loader.sv
// Directed bench for regfile_loader: a frame-level model predicts every write and
// done pulse, and a per-cycle monitor compares the write ports against it.
module tb_regfile_loader;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 32;
  localparam int STATE_W   = 18;
  localparam int MAX_WORDS = 4096;

  typedef struct {
    logic              tgt;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst_n;

  regfile_loader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STATE_W(STATE_W)) bus ();

  regfile_loader #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STATE_W(STATE_W), .MAX_WORDS(MAX_WORDS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int tests_run    = 0;
  int tests_failed = 0;

  wr_t               exp_wr[$];
  logic              exp_done[$];
  logic [31:0]       frame_words[$];
  int                done_seen     = 0;
  int                done_expected = 0;
  logic              dut_start_at_done;
  logic              exp_start;
  wr_t               w;

  int                log_cycle[$];
  logic [ADDR_W-1:0] log_addr[$];
  logic [DATA_W-1:0] log_data[$];

  logic [ADDR_W-1:0]  last_inex_addr;
  logic [DATA_W-1:0]  last_inex_data;
  logic [ADDR_W-1:0]  last_state_addr;
  logic [STATE_W-1:0] last_state_data;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Offer one byte and return just after the edge that accepts it.
  task automatic applyStimulus(input logic [7:0] b);
    int waited = 0;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    checkOutput("in_ready_wait", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
  endtask

  // Queue the model's view of a frame, then send header and frame_words.
  task automatic run_frame(input logic [7:0] cmd, input logic [15:0] addr, input logic [15:0] cnt);
    if (cmd[7:2] == 6'd0 && int'(cnt) <= MAX_WORDS) begin
      for (int i = 0; i < int'(cnt); i++) begin
        wr_t e;
        e.tgt  = cmd[0];
        e.addr = ADDR_W'((int'(addr) + i) % (1 << ADDR_W));
        e.data = cmd[0] ? (frame_words[i] & ((32'd1 << STATE_W) - 32'd1)) : frame_words[i];
        exp_wr.push_back(e);
      end
      exp_done.push_back(cmd[1]);
      done_expected++;
    end
    applyStimulus(cmd);
    applyStimulus(addr[15:8]);
    applyStimulus(addr[7:0]);
    applyStimulus(cnt[15:8]);
    applyStimulus(cnt[7:0]);
    foreach (frame_words[i])
      for (int b = 3; b >= 0; b--)
        applyStimulus(frame_words[i][8*b +: 8]);
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (done_seen < done_expected && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("done_count", done_seen, done_expected);
  endtask

  task automatic clear_log();
    log_cycle.delete();
    log_addr.delete();
    log_data.delete();
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = 8'd0;
    bus.clear_err = 1'b0;
    rst_n         = 1'b0;

    fork
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          last_inex_addr  = '0;
          last_inex_data  = '0;
          last_state_addr = '0;
          last_state_data = '0;
        end else begin
          if (bus.ran_we_InexRecur && bus.ran_we_state_external)
            checkOutput("dual_we", {31'd0, bus.ran_we_state_external}, 32'd0);
          if (bus.ran_we_InexRecur || bus.ran_we_state_external) begin
            if (exp_wr.size() == 0) begin
              checkOutput("unexpected_we_inex", {31'd0, bus.ran_we_InexRecur}, 32'd0);
              checkOutput("unexpected_we_state", {31'd0, bus.ran_we_state_external}, 32'd0);
            end else begin
              w = exp_wr.pop_front();
              checkOutput("we_inex", {31'd0, bus.ran_we_InexRecur}, {31'd0, !w.tgt});
              checkOutput("we_state", {31'd0, bus.ran_we_state_external}, {31'd0, w.tgt});
              if (w.tgt) begin
                last_state_addr = w.addr;
                last_state_data = STATE_W'(w.data);
              end else begin
                last_inex_addr = w.addr;
                last_inex_data = w.data;
              end
            end
            log_cycle.push_back(cycle);
            if (bus.ran_we_state_external) begin
              log_addr.push_back(bus.ran_w_addr_state_external);
              log_data.push_back(DATA_W'(bus.ran_w_data_state_external));
            end else begin
              log_addr.push_back(bus.ran_w_addr_InexRecur);
              log_data.push_back(bus.ran_w_data_InexRecur);
            end
          end
          checkOutput("inex_addr", 32'(bus.ran_w_addr_InexRecur), 32'(last_inex_addr));
          checkOutput("inex_data", bus.ran_w_data_InexRecur, last_inex_data);
          checkOutput("state_addr", 32'(bus.ran_w_addr_state_external), 32'(last_state_addr));
          checkOutput("state_data", 32'(bus.ran_w_data_state_external), 32'(last_state_data));
          if (bus.done) begin
            done_seen++;
            dut_start_at_done = bus.is_start;
            if (exp_done.size() == 0) begin
              checkOutput("unexpected_done", {31'd0, bus.done}, 32'd0);
            end else begin
              exp_start = exp_done.pop_front();
              checkOutput("is_start_with_done", {31'd0, bus.is_start}, {31'd0, exp_start});
            end
          end else if (bus.is_start) begin
            checkOutput("is_start_without_done", {31'd0, bus.is_start}, 32'd0);
          end
        end
      end
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("rst_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("rst_done", {31'd0, bus.done}, 32'd0);
    checkOutput("rst_err", {31'd0, bus.err}, 32'd0);
    checkOutput("rst_is_start", {31'd0, bus.is_start}, 32'd0);
    checkOutput("rst_we", {30'd0, bus.ran_we_InexRecur, bus.ran_we_state_external}, 32'd0);
    rst_n = 1'b1;

    // Two InexRecur words, no start
    clear_log();
    frame_words = '{32'h11223344, 32'hAABBCCDD};
    run_frame(8'h00, 16'h0010, 16'd2);
    wait_done();
    checkOutput("t1_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      checkOutput("t1_addr0", 32'(log_addr[0]), 32'h010);
      checkOutput("t1_data0", log_data[0], 32'h11223344);
      checkOutput("t1_addr1", 32'(log_addr[1]), 32'h011);
      checkOutput("t1_data1", log_data[1], 32'hAABBCCDD);
      checkOutput("t1_spacing", log_cycle[1] - log_cycle[0], 32'd5);
    end
    checkOutput("t1_no_start", {31'd0, dut_start_at_done}, 32'd0);

    // State target with address wrap and start pulse
    clear_log();
    frame_words = '{32'h0003FFFF, 32'h12345678};
    run_frame(8'h03, 16'h0FFF, 16'd2);
    wait_done();
    checkOutput("t2_nwrites", log_addr.size(), 32'd2);
    if (log_addr.size() == 2) begin
      checkOutput("t2_addr0", 32'(log_addr[0]), 32'hFFF);
      checkOutput("t2_data0", log_data[0], 32'h3FFFF);
      checkOutput("t2_addr1", 32'(log_addr[1]), 32'h000);
      checkOutput("t2_data1", log_data[1], 32'h05678);
    end
    checkOutput("t2_start", {31'd0, dut_start_at_done}, 32'd1);

    // Zero-length frame with start
    clear_log();
    frame_words.delete();
    run_frame(8'h02, 16'h0000, 16'd0);
    checkOutput("t3_done", {31'd0, bus.done}, 32'd1);
    checkOutput("t3_is_start", {31'd0, bus.is_start}, 32'd1);
    checkOutput("t3_busy", {31'd0, bus.busy}, 32'd1);
    @(negedge clk);
    checkOutput("t3_done_low", {31'd0, bus.done}, 32'd0);
    checkOutput("t3_ready_back", {31'd0, bus.in_ready}, 32'd1);
    wait_done();
    checkOutput("t3_nwrites", log_addr.size(), 32'd0);

    // Illegal command, ignored input while in error, recovery
    applyStimulus(8'h04);
    @(negedge clk);
    bus.in_valid = 1'b0;
    checkOutput("t4_err", {31'd0, bus.err}, 32'd1);
    checkOutput("t4_ready", {31'd0, bus.in_ready}, 32'd0);
    checkOutput("t4_busy", {31'd0, bus.busy}, 32'd0);
    bus.in_valid = 1'b1;
    bus.in_data  = 8'h00;
    repeat (3) @(negedge clk);
    checkOutput("t4_err_sticky", {31'd0, bus.err}, 32'd1);
    bus.in_valid  = 1'b0;
    bus.clear_err = 1'b1;
    @(negedge clk);
    checkOutput("t4_err_cleared", {31'd0, bus.err}, 32'd0);
    checkOutput("t4_ready_back", {31'd0, bus.in_ready}, 32'd1);
    clear_log();
    frame_words = '{32'hCAFEF00D};
    run_frame(8'h00, 16'h0100, 16'd1);
    wait_done();
    bus.clear_err = 1'b0;
    checkOutput("t4_nwrites", log_addr.size(), 32'd1);
    if (log_addr.size() == 1) begin
      checkOutput("t4_addr", 32'(log_addr[0]), 32'h100);
      checkOutput("t4_data", log_data[0], 32'hCAFEF00D);
    end

    // Count above limit errors; count at limit fills the whole regfile
    frame_words.delete();
    run_frame(8'h00, 16'h0000, 16'h1001);
    checkOutput("t5_err", {31'd0, bus.err}, 32'd1);
    bus.clear_err = 1'b1;
    @(negedge clk);
    bus.clear_err = 1'b0;
    checkOutput("t5_err_cleared", {31'd0, bus.err}, 32'd0);
    clear_log();
    for (int i = 0; i < MAX_WORDS; i++)
      frame_words.push_back({16'(i), ~16'(i)});
    run_frame(8'h00, 16'h0000, 16'h1000);
    wait_done();
    checkOutput("t5_nwrites", log_addr.size(), 32'd4096);
    if (log_addr.size() > 0) begin
      checkOutput("t5_last_addr", 32'(log_addr[log_addr.size()-1]), 32'hFFF);
      checkOutput("t5_last_data", log_data[log_data.size()-1], 32'h0FFFF000);
    end

    // Asynchronous reset mid-word abandons the frame
    frame_words.delete();
    applyStimulus(8'h00);
    applyStimulus(8'h00);
    applyStimulus(8'h20);
    applyStimulus(8'h00);
    applyStimulus(8'h01);
    applyStimulus(8'hDE);
    applyStimulus(8'hAD);
    @(negedge clk);
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    exp_wr.delete();
    exp_done.delete();
    #1;
    checkOutput("t6_in_ready", {31'd0, bus.in_ready}, 32'd1);
    checkOutput("t6_busy", {31'd0, bus.busy}, 32'd0);
    checkOutput("t6_done", {31'd0, bus.done}, 32'd0);
    checkOutput("t6_err", {31'd0, bus.err}, 32'd0);
    checkOutput("t6_inex_data", bus.ran_w_data_InexRecur, 32'd0);
    checkOutput("t6_inex_addr", 32'(bus.ran_w_addr_InexRecur), 32'd0);
    checkOutput("t6_state_data", 32'(bus.ran_w_data_state_external), 32'd0);
    repeat (3) begin
      @(negedge clk);
      checkOutput("t6_we_in_reset", {30'd0, bus.ran_we_InexRecur, bus.ran_we_state_external}, 32'd0);
    end
    rst_n = 1'b1;
    clear_log();
    frame_words = '{32'hDEADBEEF};
    run_frame(8'h01, 16'h0005, 16'd1);
    wait_done();
    checkOutput("t6_nwrites", log_addr.size(), 32'd1);
    if (log_addr.size() == 1) begin
      checkOutput("t6_addr", 32'(log_addr[0]), 32'h005);
      checkOutput("t6_data", log_data[0], 32'h1BEEF);
    end

    @(negedge clk);
    checkOutput("writes_drained", exp_wr.size(), 32'd0);
    checkOutput("done_drained", exp_done.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
